// File: rtl/rgb_pwm_driver.sv
// Tri-colour LED PWM driver: three 32-bit stb/ack duty streams become registered PWM pin drives.
// New duty values are held pending and only take effect at a period boundary, so pulses never runt.
module rgb_pwm_driver #(
   parameter int unsigned PRESCALE = 16,
   parameter int unsigned WIDTH    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_led_r,
   input  logic        input_led_r_stb,
   output logic        input_led_r_ack,
   input  logic [31:0] input_led_g,
   input  logic        input_led_g_stb,
   output logic        input_led_g_ack,
   input  logic [31:0] input_led_b,
   input  logic        input_led_b_stb,
   output logic        input_led_b_ack,
   output logic        led_r_out,
   output logic        led_g_out,
   output logic        led_b_out,
   output logic        period_start
);

   localparam int unsigned PRE_W = $clog2(PRESCALE);
   localparam int unsigned NCH   = 3;
   localparam logic [WIDTH:0]   FULL    = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [PRE_W-1:0] pre;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_n;
   logic             tick;
   logic             wrap;

   logic [31:0]      data     [NCH];
   logic [NCH-1:0]   stb;
   logic [NCH-1:0]   ack;
   logic [NCH-1:0]   pending_valid;
   logic [NCH-1:0]   out_q;
   logic [WIDTH:0]   pending  [NCH];
   logic [WIDTH:0]   active   [NCH];
   logic [WIDTH:0]   active_n [NCH];
   logic [WIDTH:0]   duty     [NCH];

   assign data[0] = input_led_r;
   assign data[1] = input_led_g;
   assign data[2] = input_led_b;
   assign stb     = {input_led_b_stb, input_led_g_stb, input_led_r_stb};

   assign input_led_r_ack = ack[0];
   assign input_led_g_ack = ack[1];
   assign input_led_b_ack = ack[2];
   assign led_r_out       = out_q[0];
   assign led_g_out       = out_q[1];
   assign led_b_out       = out_q[2];

   assign tick  = (pre == PRE_W'(PRESCALE - 1));
   assign wrap  = tick && (cnt == CNT_MAX);
   assign cnt_n = tick ? cnt + WIDTH'(1) : cnt;

   // Saturating duty mapping and the active value that will hold after this edge.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         duty[i]     = FULL;
         active_n[i] = active[i];
         if (data[i][31:WIDTH] == '0) begin
            duty[i] = {1'b0, data[i][WIDTH-1:0]};
         end
         if (wrap && pending_valid[i]) begin
            active_n[i] = pending[i];
         end
      end
   end

   // Outputs are computed from post-edge cnt/active so they line up with period_start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre           <= '0;
         cnt           <= '0;
         period_start  <= 1'b0;
         ack           <= '0;
         pending_valid <= '0;
         out_q         <= '0;
         for (int i = 0; i < NCH; i++) begin
            pending[i] <= '0;
            active[i]  <= '0;
         end
      end else begin
         pre          <= tick ? '0 : pre + PRE_W'(1);
         cnt          <= cnt_n;
         period_start <= wrap;
         for (int i = 0; i < NCH; i++) begin
            active[i] <= active_n[i];
            out_q[i]  <= ({1'b0, cnt_n} < active_n[i]);
            if (stb[i] && ack[i]) begin
               pending[i]       <= duty[i];
               pending_valid[i] <= 1'b1;
               ack[i]           <= 1'b0;
            end else if (wrap && pending_valid[i]) begin
               pending_valid[i] <= 1'b0;
               ack[i]           <= 1'b0;
            end else begin
               ack[i] <= !pending_valid[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PRESCALE=4, WIDTH=4 (64-cycle period).
module tb_rgb_pwm_driver;

   localparam int unsigned PRESCALE = 4;
   localparam int unsigned WIDTH    = 4;
   localparam int          PERIOD   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] r_d = '0, g_d = '0, b_d = '0;
   logic        r_s = 1'b0, g_s = 1'b0, b_s = 1'b0;
   logic        r_a, g_a, b_a;
   logic        led_r_out, led_g_out, led_b_out, period_start;

   int errors = 0;
   int checks = 0;

   rgb_pwm_driver #(.PRESCALE(PRESCALE), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .input_led_r(r_d), .input_led_r_stb(r_s), .input_led_r_ack(r_a),
      .input_led_g(g_d), .input_led_g_stb(g_s), .input_led_g_ack(g_a),
      .input_led_b(b_d), .input_led_b_stb(b_s), .input_led_b_ack(b_a),
      .led_r_out(led_r_out), .led_g_out(led_g_out), .led_b_out(led_b_out),
      .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents words on the masked channels and drops each stb once its transfer edge has passed.
   task automatic write3(input logic [2:0] mask, input logic [31:0] r, input logic [31:0] g,
                         input logic [31:0] b, output int edges);
      logic dr, dg, db;
      r_d = r; g_d = g; b_d = b;
      r_s = mask[0]; g_s = mask[1]; b_s = mask[2];
      edges = 0;
      while ((r_s || g_s || b_s) && edges < 200) begin
         dr = r_s && r_a; dg = g_s && g_a; db = b_s && b_a;
         step();
         edges++;
         if (dr) r_s = 1'b0;
         if (dg) g_s = 1'b0;
         if (db) b_s = 1'b0;
      end
      r_s = 1'b0; g_s = 1'b0; b_s = 1'b0;
   endtask

   task automatic wait_ps(output int n);
      n = 0;
      while (!period_start && n < 200) begin
         step();
         n++;
      end
   endtask

   // Samples one full period starting at the current cycle; completes any pending handshake.
   task automatic measure(output int hr, output int hg, output int hb, output int ps_cnt,
                          output int acc_k);
      logic dr, dg, db;
      hr = 0; hg = 0; hb = 0; ps_cnt = 0; acc_k = -1;
      for (int k = 0; k < PERIOD; k++) begin
         dr = r_s && r_a; dg = g_s && g_a; db = b_s && b_a;
         hr += led_r_out ? 1 : 0;
         hg += led_g_out ? 1 : 0;
         hb += led_b_out ? 1 : 0;
         ps_cnt += period_start ? 1 : 0;
         if ((dr || dg || db) && acc_k < 0) acc_k = k;
         step();
         if (dr) r_s = 1'b0;
         if (dg) g_s = 1'b0;
         if (db) b_s = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n;
      step(); step();
      checks++;
      if ({led_r_out, led_g_out, led_b_out, period_start} !== 4'b0000) begin
         errors++; $display("FAIL reset_outs: got %b expected 0000", {led_r_out, led_g_out, led_b_out, period_start});
      end
      checks++;
      if ({r_a, g_a, b_a} !== 3'b000) begin
         errors++; $display("FAIL reset_acks: got %b expected 000", {r_a, g_a, b_a});
      end
      rst = 1'b0;
      step();
      checks++;
      if ({r_a, g_a, b_a} !== 3'b111) begin
         errors++; $display("FAIL ack_after_release: got %b expected 111", {r_a, g_a, b_a});
      end
      wait_ps(n);
      checks++;
      if (n !== 63 || period_start !== 1'b1) begin
         errors++; $display("FAIL first_wrap: got %0d more edges (ps=%b) expected 63 (ps=1)", n, period_start);
      end
   endtask

   task automatic test_basic_duty();
      int e, n, hr, hg, hb, ps, ak;
      write3(3'b001, 32'd4, 32'd0, 32'd0, e);
      checks++;
      if (e !== 1 || r_a !== 1'b0) begin
         errors++; $display("FAIL red4_accept: got edges=%0d ack=%b expected edges=1 ack=0", e, r_a);
      end
      wait_ps(n);
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 16 || ps !== 1) begin
         errors++; $display("FAIL red4_period1: got high=%0d ps=%0d expected high=16 ps=1", hr, ps);
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 16 || ps !== 1) begin
         errors++; $display("FAIL red4_period2: got high=%0d ps=%0d expected high=16 ps=1", hr, ps);
      end
   endtask

   task automatic test_extremes();
      int e, n, hr, hg, hb, ps, ak;
      write3(3'b110, 32'd0, 32'd0, 32'h100, e);
      wait_ps(n);
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hg !== 0 || hb !== 64 || hr !== 16) begin
         errors++; $display("FAIL g0_b100: got r=%0d g=%0d b=%0d expected r=16 g=0 b=64", hr, hg, hb);
      end
      write3(3'b100, 32'd0, 32'd0, 32'hFFFF_FFFF, e);
      wait_ps(n);
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hb !== 64) begin
         errors++; $display("FAIL b_negative: got high=%0d expected 64", hb);
      end
   endtask

   task automatic test_back_to_back();
      int e, n, hr, hg, hb, ps, ak, ack_seen;
      write3(3'b001, 32'd8, 32'd0, 32'd0, e);
      r_d = 32'd2; r_s = 1'b1;
      n = 0; ack_seen = 0;
      while (!period_start && n < 200) begin
         if (r_a) ack_seen++;
         step();
         n++;
      end
      checks++;
      if (ack_seen !== 0 || period_start !== 1'b1 || r_a !== 1'b0) begin
         errors++; $display("FAIL stall_ack: got ack_high=%0d ps=%b ack=%b expected 0 1 0", ack_seen, period_start, r_a);
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 32 || ak !== 1 || r_s !== 1'b0) begin
         errors++; $display("FAIL red8_then2: got high=%0d accept_at=%0d expected high=32 accept_at=1", hr, ak);
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 8) begin
         errors++; $display("FAIL red2_applied: got high=%0d expected 8", hr);
      end
   endtask

   task automatic test_wrap_edge();
      int hr, hg, hb, ps, ak;
      for (int k = 0; k < PERIOD - 1; k++) step();
      r_d = 32'd12; r_s = 1'b1;
      checks++;
      if (period_start !== 1'b0 || r_a !== 1'b1) begin
         errors++; $display("FAIL pre_wrap: got ps=%b ack=%b expected ps=0 ack=1", period_start, r_a);
      end
      step();
      r_s = 1'b0;
      checks++;
      if (period_start !== 1'b1 || r_a !== 1'b0) begin
         errors++; $display("FAIL on_wrap_xfer: got ps=%b ack=%b expected ps=1 ack=0", period_start, r_a);
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 8 || ps !== 1 || period_start !== 1'b1) begin
         errors++; $display("FAIL wrap_current: got high=%0d ps=%0d next_ps=%b expected 8 1 1", hr, ps, period_start);
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 48 || ps !== 1) begin
         errors++; $display("FAIL wrap_next: got high=%0d ps=%0d expected 48 1", hr, ps);
      end
   endtask

   task automatic test_async_reset();
      int e, highs, first;
      write3(3'b001, 32'd3, 32'd0, 32'd0, e);
      for (int k = 0; k < 5; k++) step();
      checks++;
      if (led_r_out !== 1'b1) begin
         errors++; $display("FAIL red12_high: got %b expected 1", led_r_out);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({led_r_out, period_start, r_a, g_a, b_a} !== 5'b00000) begin
         errors++; $display("FAIL async_reset: got %b expected 00000", {led_r_out, period_start, r_a, g_a, b_a});
      end
      #2 rst = 1'b0;
      highs = 0; first = -1;
      for (int k = 1; k <= 150; k++) begin
         step();
         highs += (led_r_out || led_g_out || led_b_out) ? 1 : 0;
         if (period_start && first < 0) first = k;
      end
      checks++;
      if (highs !== 0) begin
         errors++; $display("FAIL post_reset_low: got %0d high cycles expected 0", highs);
      end
      checks++;
      if (first !== 64) begin
         errors++; $display("FAIL post_reset_wrap: got ps at edge %0d expected 64", first);
      end
   endtask

   task automatic test_simultaneous();
      int e, n, hr, hg, hb, ps, ak;
      write3(3'b111, 32'd1, 32'd15, 32'd16, e);
      checks++;
      if (e !== 1) begin
         errors++; $display("FAIL same_edge_accept: got %0d edges expected 1", e);
      end
      wait_ps(n);
      checks++;
      if ({period_start, led_r_out, led_g_out, led_b_out} !== 4'b1111) begin
         errors++; $display("FAIL aligned_rise: got %b expected 1111", {period_start, led_r_out, led_g_out, led_b_out});
      end
      measure(hr, hg, hb, ps, ak);
      checks++;
      if (hr !== 4 || hg !== 60 || hb !== 64) begin
         errors++; $display("FAIL rgb_duty: got r=%0d g=%0d b=%0d expected 4 60 64", hr, hg, hb);
      end
   endtask

   initial begin
      test_reset();
      test_basic_duty();
      test_extremes();
      test_back_to_back();
      test_wrap_edge();
      test_async_reset();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Converts the three colour-LED word streams produced by the generated user design (`led_r`, `led_g`, `led_b`) into glitch-free PWM pin drives for the board's tri-colour LED. It sits directly downstream of the user design, consuming each 32-bit stb/ack stream. Each accepted word becomes a duty-cycle value. New duty values are applied only at a PWM period boundary, so no channel ever produces a runt pulse.

## Interface
- `PRESCALE`, default 16: clock cycles per PWM tick, ≥2.
- `WIDTH`, default 8: duty resolution in bits; one period = 2^WIDTH ticks.

Ports:
- `clk` in, 1 bit: system clock; all state changes on its rising edge.
- `rst` in, 1 bit: reset, asynchronous and active-high.
- `input_led_r` in, 32 bits: red duty word.
- `input_led_r_stb` in, 1 bit: red word valid.
- `input_led_r_ack` out, 1 bit: red word accepted when high together with stb.
- `input_led_g`, `input_led_g_stb`, `input_led_g_ack`: green channel, identical to red.
- `input_led_b`, `input_led_b_stb`, `input_led_b_ack`: blue channel, identical to red.
- `led_r_out`, `led_g_out`, `led_b_out` out, 1 bit each: registered PWM pin drives, active-high.
- `period_start` out, 1 bit: one-cycle pulse on the first clock of each PWM period.

## Operation
Prescaler:
- `pre` counts 0..PRESCALE-1 and wraps.
- `tick` = (`pre` == PRESCALE-1).

Period counter:
- `cnt`, WIDTH bits, increments on `tick` and wraps from 2^WIDTH-1 to 0.
- `wrap` = `tick` && (`cnt` == 2^WIDTH-1).

Per channel state:
- `pending` (WIDTH+1 bits), `pending_valid`, `active` (WIDTH+1 bits), registered `ack`.

Handshake:
- A transfer occurs on any edge where stb && ack.
- On a transfer: `pending` ← duty(data), `pending_valid` ← 1, ack ← 0.
- ack = !`pending_valid`, registered. It is held low while a value is pending.
- stb may stay high while ack is low; the word is taken once ack rises.

Duty mapping:
- If data[31:WIDTH] == 0, duty = data[WIDTH-1:0].
- Otherwise duty = 2^WIDTH (saturate).
- Negative words saturate too, since their upper bits are nonzero.

Apply on wrap:
- If `pending_valid`: `active` ← `pending`, `pending_valid` ← 0, ack ← 1 next cycle.
- If no value is pending, `active` is unchanged.

Output:
- out ← (`cnt` < `active`), compared at WIDTH+1 bits and registered.
- duty 0 gives a constant low output.
- duty 2^WIDTH gives a constant high output.
- duty d gives d×PRESCALE high cycles per period.

Channels are fully independent apart from the shared `pre` and `cnt`.

## Timing
Reset:
- `pre`, `cnt`, `active`, `pending`, `pending_valid` = 0.
- All `*_out` = 0, `period_start` = 0, all ack = 0.

After reset release:
- ack rises on the first clock edge.
- `cnt` = 0 and `pre` = 0 at release; the first `wrap` occurs at cycle 2^WIDTH×PRESCALE-1.

`period_start`:
- Registered copy of `wrap`.
- High on the same cycle the outputs first reflect `cnt` = 0 and the new `active`.

Latency from accept to pin:
- A word accepted at edge E is applied at the first `wrap` edge after E.
- The pin changes one cycle after that `wrap` edge.
- Worst case is one full period + 1 cycle.

Transfer and `wrap` on the same edge:
- Cannot conflict: ack = 1 implies `pending_valid` = 0.
- The new value waits for the next `wrap`.

Back-to-back writes:
- Only one word is pending per channel.
- The second word is stalled with ack low until the next `wrap`.
- The second word is not dropped or overwritten.

Reset mid-period:
- Outputs go low immediately (asynchronous).
- Any pending value is discarded.

## Test plan
All scenarios use PRESCALE=4, WIDTH=4, so one period = 64 cycles.

1. Reset, then stb red = 4 → ack high within 1 cycle; transfer; from the next `period_start`, `led_r_out` is high 16 cycles and low 48, repeating.
2. Write green = 0 and blue = 0x100 → `led_g_out` is constantly 0 and `led_b_out` is constantly 1 after the next `period_start`; blue = 0xFFFFFFFF is also constantly 1.
3. Write red = 8, then immediately present red = 2 with stb held → ack stays low until the `wrap`; the next period has 32 high cycles; value 2 is accepted after that `wrap` and gives 8 high cycles one period later.
4. Apply stb exactly on the `wrap` edge → the value is applied one period later, not in the current period; `period_start` pulses every 64 cycles.
5. Assert `rst` asynchronously mid-period with red duty 12 active → `led_r_out`, `period_start` and all ack drop immediately; after release the output stays 0 until a new word is applied.
6. Write r=1, g=15, b=16 simultaneously → all three accepted on the same edge; high times of 4, 60 and 64 cycles respectively, with all rising edges aligned to `period_start`.
